// File: rtl/freq_counter_pkg.sv
// Shared types and widths for the multi-channel BCD frequency counter.
package freq_counter_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned DROP_W       = 8;
    localparam int unsigned CHAN_W       = 3;
    localparam int unsigned MAX_CHANNELS = 1 << CHAN_W;

endpackage

// File: rtl/freq_channel.sv
// One measured input: 2-flop synchroniser, registered rising-edge detector,
// saturating DIGITS-digit BCD counter and per-window overflow flag.
module freq_channel
    import freq_counter_pkg::*;
#(
    parameter int unsigned DIGITS = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_x,
    input  logic                        i_en,
    input  logic                        i_gate_end,
    output logic [DIGIT_W*DIGITS-1:0]   o_cnt,
    output logic                        o_ovf
);

    localparam int unsigned CNT_W = DIGIT_W * DIGITS;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_carry;
    logic             w_all9;

    // The registered edge pulse puts a sampled rise on the counter 3 cycles later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_x;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_rise  <= r_sync2 & ~r_sync3;
        end
    end

    always_comb begin
        w_cnt_inc = r_cnt;
        w_carry   = 1'b1;
        w_all9    = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_cnt[d*DIGIT_W +: DIGIT_W] != 4'd9) begin
                w_all9 = 1'b0;
            end
            if (w_carry) begin
                if (r_cnt[d*DIGIT_W +: DIGIT_W] == 4'd9) begin
                    w_cnt_inc[d*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    w_cnt_inc[d*DIGIT_W +: DIGIT_W] = r_cnt[d*DIGIT_W +: DIGIT_W] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_gate_end) begin
            // An edge landing on the gate boundary belongs to the next window.
            r_cnt <= r_rise ? CNT_W'(1) : '0;
            r_ovf <= 1'b0;
        end else if (r_rise) begin
            if (w_all9) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/multi_channel_freq_counter.sv
// Gated multi-channel frequency counter: per-window BCD snapshots are streamed
// out one channel per valid/ready handshake; windows arriving mid-transfer are dropped.
module multi_channel_freq_counter
    import freq_counter_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DIGITS      = 6,
    parameter int unsigned GATE_CYCLES = 1000000
) (
    input  logic                        clk_ref_in,
    input  logic                        reset_in,
    input  logic [CHANNELS-1:0]         clk_x_in,
    input  logic                        en_in,
    output logic                        res_valid_out,
    input  logic                        res_ready_in,
    output logic [CHAN_W-1:0]           res_chan_out,
    output logic [DIGIT_W*DIGITS-1:0]   res_bcd_out,
    output logic                        res_ovf_out,
    output logic [DROP_W-1:0]           drop_cnt_out
);

    localparam int unsigned CNT_W = DIGIT_W * DIGITS;
    localparam int unsigned TMR_W = $clog2(GATE_CYCLES);

    logic [TMR_W-1:0]        r_timer;
    logic                    w_gate_end;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CHAN_W-1:0]       r_ptr;
    logic [CHAN_W-1:0]       w_ptr_nxt;
    logic                    w_load;
    logic                    w_drop_inc;
    logic                    w_last;
    logic [DROP_W-1:0]       r_drop;
    logic [CNT_W-1:0]        w_cnt     [MAX_CHANNELS];
    logic [MAX_CHANNELS-1:0] w_ovf;
    logic [CNT_W-1:0]        r_buf_bcd [MAX_CHANNELS];
    logic [MAX_CHANNELS-1:0] r_buf_ovf;

    assign w_gate_end = en_in && (r_timer == TMR_W'(GATE_CYCLES - 1));

    // Unused slots are tied off so the pointer can index a full power-of-two buffer.
    for (genvar g = 0; g < MAX_CHANNELS; g++) begin : g_ch
        if (g < CHANNELS) begin : g_inst
            freq_channel #(
                .DIGITS (DIGITS)
            ) u_ch (
                .i_clk      (clk_ref_in),
                .i_rst      (reset_in),
                .i_x        (clk_x_in[g]),
                .i_en       (en_in),
                .i_gate_end (w_gate_end),
                .o_cnt      (w_cnt[g]),
                .o_ovf      (w_ovf[g])
            );
        end else begin : g_tie
            assign w_cnt[g] = '0;
            assign w_ovf[g] = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_load        = 1'b0;
        w_drop_inc    = 1'b0;
        w_last        = (r_ptr == CHAN_W'(CHANNELS - 1));
        res_valid_out = 1'b0;
        res_chan_out  = '0;
        res_bcd_out   = '0;
        res_ovf_out   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gate_end) begin
                    w_load      = 1'b1;
                    w_ptr_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                res_valid_out = 1'b1;
                res_chan_out  = r_ptr;
                res_bcd_out   = r_buf_bcd[r_ptr];
                res_ovf_out   = r_buf_ovf[r_ptr];
                w_drop_inc    = w_gate_end;
                if (res_ready_in) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_drop  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_drop_inc && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
            if (!en_in || w_gate_end) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
                r_buf_bcd[i] <= '0;
            end
            r_buf_ovf <= '0;
        end else if (w_load) begin
            for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
                r_buf_bcd[i] <= w_cnt[i];
            end
            r_buf_ovf <= w_ovf;
        end
    end

    assign drop_cnt_out = r_drop;

endmodule

// File: doc/multi_channel_freq_counter.md
MULTI_CHANNEL_FREQ_COUNTER -- requirements
Module: multi_channel_freq_counter

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent measured inputs, 1..8.
REQ-002 Parameter DIGITS, default 6: BCD digits per channel count, 1..8.
REQ-003 Parameter GATE_CYCLES, default 1000000: gate window length in clk_ref_in cycles, >=4.
REQ-004 clk_ref_in  in  1  sole clock, reference timebase.
REQ-005 reset_in  in  1  asynchronous, active-high reset.
REQ-006 clk_x_in  in  CHANNELS  asynchronous measured signals, one bit per channel.
REQ-007 en_in  in  1  measurement enable.
REQ-008 res_valid_out  out  1  result word valid.
REQ-009 res_ready_in  in  1  consumer (display driver) accepts result.
REQ-010 res_chan_out  out  3  channel index of the presented result.
REQ-011 res_bcd_out  out  4*DIGITS  BCD count, digit 0 in bits [3:0].
REQ-012 res_ovf_out  out  1  presented count saturated in its window.
REQ-013 drop_cnt_out  out  8  number of gate windows discarded for backpressure.

Function
REQ-014 Each clk_x_in bit SHALL pass a 2-flop synchroniser and a rising-edge detector; an input rising edge is counted 3 clk_ref_in cycles after it is sampled.
REQ-015 The gate timer SHALL count 0..GATE_CYCLES-1 and assert a one-cycle gate_end when at GATE_CYCLES-1, then wrap to 0.
REQ-016 Per-channel counter: DIGITS-digit BCD, +1 per detected edge, carry ripples digit 9->0 within the same cycle.
REQ-017 At all-9s, a further edge SHALL leave the count at all-9s and set the channel overflow flag for that window.
REQ-018 On gate_end, each count and overflow flag SHALL be captured as the window result, and the counter SHALL restart at 0, or at 1 if an edge is detected in the gate_end cycle; the overflow flag clears.
REQ-019 Output FSM states: IDLE, SEND.
- IDLE + gate_end: load snapshot buffer, channel pointer=0, go to SEND.
- SEND: res_valid_out=1, and res_chan_out/res_bcd_out/res_ovf_out come from the buffer at the pointer.
- valid&&ready: pointer+1. On the last channel, go to IDLE in the next cycle.
REQ-020 While valid=1 and ready=0, outputs SHALL remain stable.
REQ-021 A gate_end in SEND SHALL leave the buffer unchanged, and drop_cnt_out SHALL increment, saturating at 255.
REQ-022 A gate_end in the cycle where the last handshake completes counts as a drop; that window's capture is discarded.
REQ-023 en_in=0: the gate timer and all channel counters SHALL be held at 0, no gate_end is produced, and a SEND in progress completes normally.
REQ-024 en_in 0->1: the first window SHALL start at timer value 0 in the cycle after en_in rises.
REQ-025 While res_valid_out=0, res_chan_out/res_bcd_out/res_ovf_out SHALL be 0.

Reset
REQ-026 reset_in=1 SHALL asynchronously clear the synchronisers, edge detectors, gate timer, counters, overflow flags, snapshot buffer, and pointer; the FSM goes to IDLE.
REQ-027 Output values during reset: res_valid_out=0, res_chan_out=0, res_bcd_out=0, res_ovf_out=0, drop_cnt_out=0.
REQ-028 Reset mid-SEND SHALL abandon the transfer; the first window after release starts at timer 0.

Structure
REQ-029 Package freq_counter_pkg SHALL hold the FSM state enum, BCD digit width (4), the drop counter width (8), and the channel-index width (3).
REQ-030 One sub-module, freq_channel, SHALL contain the synchroniser, edge detector, BCD counter, and overflow flag for one channel, instantiated CHANNELS times.

Verification (CHANNELS=2, DIGITS=3, GATE_CYCLES=100 unless stated)
REQ-031 Basic count:
- stimulus: ch0 period 10 ref cycles, ch1 period 4, ready=1.
- response per window: chan0 bcd=0x010, then chan1 bcd=0x025, ovf=0.
REQ-032 Saturation:
- stimulus: GATE_CYCLES=2500, ch0 toggling every ref cycle.
- response: bcd=0x999, ovf=1; next window ovf=0 if the input is stopped.
REQ-033 Backpressure:
- stimulus: ready=0 for 250 cycles after the first valid.
- response: data stable throughout, drop_cnt_out=2, then both channels delivered with the original window values.
REQ-034 Boundary edge:
- stimulus: a ch0 edge detected in the gate_end cycle.
- response: the captured value excludes it, and the next window's count includes it (counter restarts at 1).
REQ-035 Reset and enable:
- stimulus: reset asserted mid-SEND.
- response: all outputs 0 immediately, and the first post-reset result appears 100 cycles after release.
- stimulus: en_in=0.
- response: no valid is ever produced.
